// File: rtl/efuse_array_emu.sv
// efuse_array_emu: 256-bit one-time-programmable eFuse model with pulse-width timing checks
module efuse_array_emu #(
  parameter int unsigned TRD_MIN = 4,
  parameter int unsigned TPGM_MIN = 16,
  parameter logic [255:0] INIT_FUSE = 256'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         efuse_pgmen_i,
  input  logic         efuse_rden_i,
  input  logic         efuse_aen_i,
  input  logic [7:0]   efuse_addr_i,
  output logic [7:0]   efuse_rdata_o,
  output logic         err_o,
  output logic [1:0]   err_code_o,
  output logic [8:0]   pgm_cnt_o,
  output logic [255:0] fuse_array_o
);
  typedef enum logic [1:0] {IDLE, RD_PULSE, PG_PULSE, ABORT} state_t;
  state_t state, state_nx;
  logic [9:0] cnt;
  logic [7:0] addr_q;
  logic err_now, rd_commit, pg_commit, changed, in_pulse_nx;
  logic [1:0] code_now;
  assign changed = efuse_addr_i != addr_q || efuse_rden_i != (state == RD_PULSE) ||
                   efuse_pgmen_i != (state == PG_PULSE);
  assign in_pulse_nx = state_nx == RD_PULSE || state_nx == PG_PULSE;
  always_comb begin
    state_nx = state;
    err_now = 1'b0;
    code_now = 2'd0;
    rd_commit = 1'b0;
    pg_commit = 1'b0;
    unique case (state)
      IDLE: if (efuse_aen_i) begin
        if (efuse_rden_i ^ efuse_pgmen_i) begin
          state_nx = efuse_rden_i ? RD_PULSE : PG_PULSE;
        end else begin
          state_nx = ABORT;
          err_now = 1'b1;
          code_now = 2'd1;
        end
      end
      RD_PULSE, PG_PULSE: if (efuse_aen_i) begin
        if (changed) begin
          state_nx = ABORT;
          err_now = 1'b1;
          code_now = 2'd3;
        end
      end else begin
        state_nx = IDLE;
        rd_commit = state == RD_PULSE && cnt >= 10'(TRD_MIN);
        pg_commit = state == PG_PULSE && cnt >= 10'(TPGM_MIN);
        err_now = !(rd_commit || pg_commit);
        code_now = err_now ? 2'd2 : 2'd0;
      end
      ABORT: state_nx = efuse_aen_i ? ABORT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      efuse_rdata_o <= 8'h00;
      err_o <= 1'b0;
      err_code_o <= 2'd0;
      pgm_cnt_o <= '0;
      fuse_array_o <= INIT_FUSE;
    end else begin
      state <= state_nx;
      cnt <= in_pulse_nx ? (state == IDLE ? 10'd1 : cnt + 10'(cnt != 10'h3ff)) : '0;
      if (state == IDLE) addr_q <= efuse_addr_i;
      err_o <= err_now;
      if (err_now) err_code_o <= code_now;
      if (rd_commit) efuse_rdata_o <= fuse_array_o[{addr_q[7:3], 3'b000} +: 8];
      // Re-programming a blown bit still counts; OR-ing keeps fuses monotonic 0->1.
      if (pg_commit) begin
        fuse_array_o[addr_q] <= 1'b1;
        pgm_cnt_o <= pgm_cnt_o + 9'(pgm_cnt_o != 9'h1ff);
      end
    end
  end
endmodule

// File: tb/tb_efuse_array_emu.sv
// tb_efuse_array_emu: directed self-checking bench for efuse_array_emu
module tb_efuse_array_emu;
  localparam logic [255:0] INIT = 256'hA500;
  logic clk = 1'b0, rst = 1'b1, pgmen = 1'b0, rden = 1'b0, aen = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] rdata;
  logic err;
  logic [1:0] code;
  logic [8:0] pgm_cnt;
  logic [255:0] fuses, exp_fuse;
  int checks = 0, errors = 0;

  efuse_array_emu #(.TRD_MIN(4), .TPGM_MIN(16), .INIT_FUSE(INIT)) dut (
    .clk(clk), .rst(rst), .efuse_pgmen_i(pgmen), .efuse_rden_i(rden), .efuse_aen_i(aen),
    .efuse_addr_i(addr), .efuse_rdata_o(rdata), .err_o(err), .err_code_o(code),
    .pgm_cnt_o(pgm_cnt), .fuse_array_o(fuses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; aen is seen high on exactly w rising edges.
  task automatic pulse(input logic p, input logic r, input logic [7:0] a, input int w);
    pgmen = p;
    rden = r;
    addr = a;
    aen = 1'b1;
    repeat (w) @(negedge clk);
    aen = 1'b0;
    pgmen = 1'b0;
    rden = 1'b0;
  endtask

  initial begin
    exp_fuse = INIT;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_err", err, 0);
    check("rst_code", code, 0);
    check("rst_pgm_cnt", pgm_cnt, 0);
    check("rst_fuses", fuses, INIT);
    rst = 1'b0;
    @(negedge clk);
    pulse(0, 1, 8'h08, 4);
    @(negedge clk);
    check("rd_init_rdata", rdata, 8'hA5);
    check("rd_init_err", err, 0);
    pulse(1, 0, 8'h13, 16);
    @(negedge clk);
    exp_fuse[19] = 1'b1;
    check("pg13_err", err, 0);
    check("pg13_cnt", pgm_cnt, 1);
    check("pg13_fuses", fuses, exp_fuse);
    pulse(0, 1, 8'h10, 4);
    @(negedge clk);
    check("rd10_rdata", rdata, 8'h08);
    pulse(1, 0, 8'h20, 15);
    @(negedge clk);
    check("short_pg_err", err, 1);
    check("short_pg_code", code, 2);
    check("short_pg_fuses", fuses, exp_fuse);
    check("short_pg_cnt", pgm_cnt, 1);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    pulse(0, 1, 8'h08, 3);
    @(negedge clk);
    check("short_rd_err", err, 1);
    check("short_rd_code", code, 2);
    check("short_rd_rdata", rdata, 8'h08);
    pgmen = 1'b1;
    rden = 1'b1;
    addr = 8'h20;
    aen = 1'b1;
    @(negedge clk);
    check("conflict_err", err, 1);
    check("conflict_code", code, 1);
    @(negedge clk);
    check("abort_quiet", err, 0);
    repeat (3) @(negedge clk);
    aen = 1'b0;
    pgmen = 1'b0;
    rden = 1'b0;
    @(negedge clk);
    check("abort_exit_err", err, 0);
    check("conflict_fuses", fuses, exp_fuse);
    pulse(0, 1, 8'h08, 4);
    @(negedge clk);
    check("post_abort_rdata", rdata, 8'hA5);
    check("post_abort_code", code, 1);
    rden = 1'b1;
    addr = 8'h00;
    aen = 1'b1;
    @(negedge clk);
    addr = 8'h08;
    @(negedge clk);
    check("chg_err", err, 1);
    check("chg_code", code, 3);
    repeat (2) @(negedge clk);
    aen = 1'b0;
    rden = 1'b0;
    @(negedge clk);
    check("chg_abort_err", err, 0);
    check("chg_rdata", rdata, 8'hA5);
    aen = 1'b1;
    @(negedge clk);
    check("none_en_err", err, 1);
    check("none_en_code", code, 1);
    aen = 1'b0;
    @(negedge clk);
    pulse(0, 1, 8'h10, 4);
    @(negedge clk);
    check("b2b_first", rdata, 8'h08);
    pulse(0, 1, 8'h08, 4);
    @(negedge clk);
    check("b2b_second", rdata, 8'hA5);
    check("b2b_err", err, 0);
    pulse(1, 0, 8'h13, 16);
    @(negedge clk);
    check("repg_cnt", pgm_cnt, 2);
    check("repg_fuses", fuses, exp_fuse);
    pgmen = 1'b1;
    addr = 8'h20;
    aen = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rdata", rdata, 8'h00);
    check("midrst_err", err, 0);
    check("midrst_code", code, 0);
    check("midrst_cnt", pgm_cnt, 0);
    check("midrst_fuses", fuses, INIT);
    @(negedge clk);
    rst = 1'b0;
    exp_fuse = INIT;
    repeat (16) @(negedge clk);
    aen = 1'b0;
    pgmen = 1'b0;
    @(negedge clk);
    exp_fuse[32] = 1'b1;
    check("postrst_pg_err", err, 0);
    check("postrst_pg_cnt", pgm_cnt, 1);
    check("postrst_pg_fuses", fuses, exp_fuse);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
